// File: rtl/idct_pkg.sv
// Shared constants, cosine ROM, rounding/saturation helpers and the stream
// port shape for the 8x8 inverse DCT.
package idct_pkg;

  localparam int IN_WIDTH  = 12;
  localparam int MID_WIDTH = 14;
  localparam int OUT_WIDTH = 10;
  localparam int COEF_FRAC = 12;
  localparam int COEF_W    = COEF_FRAC + 2;

  // Same shape as the forward pipeline's port bundle.
  typedef struct packed {
    logic                 valid;
    logic [OUT_WIDTH-1:0] data;
  } idct_port_t;

  // C(n,u) = round(2^COEF_FRAC * k(u)/2 * cos((2n+1)u*pi/16)).
  // The phase (2n+1)*u is folded modulo 32 onto the first quadrant so
  // only nine magnitudes need storing.
  function automatic logic signed [COEF_W-1:0] idct_coef(input logic [2:0] n,
                                                         input logic [2:0] u);
    logic [6:0]               phase;
    logic [4:0]               m;
    logic                     neg;
    logic signed [COEF_W-1:0] mag;
    phase = 7'({n, 1'b1}) * 7'(u);
    m     = phase[4:0];
    neg   = 1'b0;
    if (m > 5'd16) m = 5'(6'd32 - {1'b0, m});
    if (m > 5'd8) begin
      m   = 5'(5'd16 - m);
      neg = 1'b1;
    end
    case (m)
      5'd0:    mag = COEF_W'(2048);
      5'd1:    mag = COEF_W'(2009);
      5'd2:    mag = COEF_W'(1892);
      5'd3:    mag = COEF_W'(1703);
      5'd4:    mag = COEF_W'(1448);
      5'd5:    mag = COEF_W'(1138);
      5'd6:    mag = COEF_W'(784);
      5'd7:    mag = COEF_W'(400);
      default: mag = '0;
    endcase
    if (u == 3'd0) return COEF_W'(1448);
    return neg ? -mag : mag;
  endfunction

  // Round-half-up then drop the fractional bits of a cosine product sum.
  function automatic logic signed [31:0] round_frac(input logic signed [31:0] acc);
    return (acc + (32'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
  endfunction

  // Clamp to the signed range of a w-bit word.
  function automatic logic signed [31:0] sat_to(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/idct_1d8.sv
// Serial 8-point 1-D IDCT: eight MAC accumulators, a shadow register holding
// the rounded/saturated results, and a one-word-per-cycle serial output.
module idct_1d8
  import idct_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             busy
);

  localparam int ACC_W = IN_W + COEF_FRAC + 4;

  logic [2:0]              smp_q, smp_d;
  logic signed [ACC_W-1:0] acc_q [8];
  logic signed [ACC_W-1:0] acc_d [8];
  logic [OUT_W-1:0]        shadow_q [8];
  logic [OUT_W-1:0]        shadow_d [8];
  logic                    ser_act_q, ser_act_d;
  logic [2:0]              ser_idx_q, ser_idx_d;
  logic signed [ACC_W-1:0] sum [8];
  logic signed [IN_W-1:0]  x_s;

  assign x_s = in_data;

  // One multiplier per output point; sample 0 restarts the accumulation.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mac
    logic signed [ACC_W-1:0] prod;
    assign prod    = ACC_W'(x_s) * ACC_W'(idct_coef(3'(gi), smp_q));
    assign sum[gi] = (smp_q == 3'd0) ? prod : acc_q[gi] + prod;
  end

  // Accumulate, capture finished results into the shadow, walk the shadow out.
  always_comb begin
    smp_d     = smp_q;
    ser_act_d = ser_act_q;
    ser_idx_d = ser_idx_q;
    for (int n = 0; n < 8; n++) begin
      acc_d[n]    = acc_q[n];
      shadow_d[n] = shadow_q[n];
    end
    if (ser_act_q) begin
      ser_idx_d = ser_idx_q + 3'd1;
      if (ser_idx_q == 3'd7) ser_act_d = 1'b0;
    end
    if (in_valid) begin
      smp_d = smp_q + 3'd1;
      for (int n = 0; n < 8; n++) acc_d[n] = sum[n];
      // The last sample's product is folded in directly so the shadow holds
      // the finished vector on the very next cycle.
      if (smp_q == 3'd7) begin
        for (int n = 0; n < 8; n++)
          shadow_d[n] = OUT_W'(sat_to(round_frac(32'(sum[n])), OUT_W));
        ser_act_d = 1'b1;
        ser_idx_d = 3'd0;
      end
    end
    if (flush) begin
      smp_d     = '0;
      ser_act_d = 1'b0;
      ser_idx_d = '0;
      for (int n = 0; n < 8; n++) begin
        acc_d[n]    = '0;
        shadow_d[n] = '0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q     <= '0;
      ser_act_q <= 1'b0;
      ser_idx_q <= '0;
      for (int n = 0; n < 8; n++) begin
        acc_q[n]    <= '0;
        shadow_q[n] <= '0;
      end
    end else begin
      smp_q     <= smp_d;
      ser_act_q <= ser_act_d;
      ser_idx_q <= ser_idx_d;
      for (int n = 0; n < 8; n++) begin
        acc_q[n]    <= acc_d[n];
        shadow_q[n] <= shadow_d[n];
      end
    end
  end

  assign out_valid = ser_act_q;
  assign out_data  = shadow_q[ser_idx_q];
  assign out_idx   = ser_idx_q;
  assign busy      = (smp_q != 3'd0) || ser_act_q;

endmodule

// File: rtl/idct_8x8_stream.sv
// Streaming 8x8 inverse DCT: row engine -> ping-pong transpose RAM -> column
// engine. Pixels leave column-major, 64 per block, out_last on the 64th.
module idct_8x8_stream
  import idct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  logic                 row_valid, row_busy;
  logic [MID_WIDTH-1:0] row_data;
  logic [2:0]           row_idx;
  logic                 col_valid, col_busy;
  logic [OUT_WIDTH-1:0] col_data;
  logic [2:0]           col_idx;

  logic [2:0] wr_row_q, wr_row_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic [5:0] rd_cnt_q, rd_cnt_d;
  logic       rd_vld_q, rd_vld_d;
  logic [2:0] out_col_q, out_col_d;

  logic                 wr_en, rd_en;
  logic [6:0]           wr_addr, rd_addr;
  logic [MID_WIDTH-1:0] bank_mem [128];
  logic [MID_WIDTH-1:0] mem_rd_data;
  idct_port_t           out_port;

  idct_1d8 #(.IN_W(IN_WIDTH), .OUT_W(MID_WIDTH)) u_row (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(row_valid), .out_data(row_data), .out_idx(row_idx), .busy(row_busy)
  );

  idct_1d8 #(.IN_W(MID_WIDTH), .OUT_W(OUT_WIDTH)) u_col (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(rd_vld_q), .in_data(mem_rd_data),
    .out_valid(col_valid), .out_data(col_data), .out_idx(col_idx), .busy(col_busy)
  );

  // Two 64-word banks; the bank bit is the address MSB. Row results land at
  // row*8+n, the column sequencer reads v*8+x with v cycling fastest.
  assign wr_en   = row_valid && !flush;
  assign wr_addr = {wr_bank_q, wr_row_q, row_idx};
  assign rd_en   = full_q[rd_bank_q] && !flush;
  assign rd_addr = {rd_bank_q, rd_cnt_q[2:0], rd_cnt_q[5:3]};

  // Transpose RAM with registered read.
  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[wr_addr] <= row_data;
    if (rd_en) mem_rd_data <= bank_mem[rd_addr];
  end

  // Bank handover: writer fills and toggles, reader drains a full bank and releases it.
  always_comb begin
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    rd_cnt_d  = rd_cnt_q;
    rd_vld_d  = rd_en;
    out_col_d = out_col_q;
    if (full_q[rd_bank_q]) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
    if (row_valid && row_idx == 3'd7) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (col_valid && col_idx == 3'd7) out_col_d = out_col_q + 3'd1;
    if (flush) begin
      wr_row_d  = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      full_d    = '0;
      rd_cnt_d  = '0;
      rd_vld_d  = 1'b0;
      out_col_d = '0;
    end
  end

  // Pointer, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      rd_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      out_col_q <= '0;
    end else begin
      wr_row_q  <= wr_row_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      out_col_q <= out_col_d;
    end
  end

  assign out_port.valid = col_valid;
  assign out_port.data  = col_data;
  assign out_valid      = out_port.valid;
  assign out_data       = out_port.data;
  assign out_last       = col_valid && (out_col_q == 3'd7) && (col_idx == 3'd7);
  assign busy           = row_busy || col_busy || (wr_row_q != 3'd0) || (|full_q) || rd_vld_q;

endmodule

// File: tb/tb_idct_8x8_stream.sv
// Directed bench for idct_8x8_stream with a queue scoreboard fed from a
// floating-point-derived bit-exact reference model.
module tb_idct_8x8_stream;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [11:0]       in_data;
  logic              out_valid;
  logic signed [9:0] out_data;
  logic              out_last;
  logic              busy;

  idct_8x8_stream dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   start_cycs[$];
  int   start_vals[$];
  int   n_asserts = 0;
  int   n_fail = 0;
  int   cur[64];
  int   blk0[64];
  int   in63_cyc = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_asserts++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cref(input int n, input int u);
    real r;
    if (u == 0) r = 2048.0 / $sqrt(2.0);
    else r = 2048.0 * $cos(real'((2 * n + 1) * u) * 3.14159265358979 / 16.0);
    return int'(r);
  endfunction

  function automatic int rsat(input longint a, input int w);
    longint v, hi, lo;
    v  = (a + 2048) >>> 12;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return int'(v);
  endfunction

  task automatic push_model();
    int     mid[64];
    longint acc;
    exp_t   e;
    for (int v = 0; v < 8; v++)
      for (int n = 0; n < 8; n++) begin
        acc = 0;
        for (int u = 0; u < 8; u++) acc += longint'(cref(n, u)) * cur[v * 8 + u];
        mid[v * 8 + n] = rsat(acc, 14);
      end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        acc = 0;
        for (int v = 0; v < 8; v++) acc += longint'(cref(y, v)) * mid[v * 8 + x];
        e.data = rsat(acc, 10);
        e.last = (x == 7 && y == 7);
        sb.push_back(e);
      end
  endtask

  task automatic push_const(input int val);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.data = val;
      e.last = (i == 63);
      sb.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_block(input int gap_pct, input int n_in);
    for (int i = 0; i < n_in; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        tick(1);
      end
      in_valid = 1'b1;
      in_data  = 12'(cur[i]);
      if (i == 63) in63_cyc = cyc;
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_drain_left"}, sb.size(), 0);
  endtask

  // Pops one expectation per out_valid; any reset/flush discards what is pending.
  task automatic monitor();
    int   pix = 0;
    bit   prev_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || flush) begin
        sb.delete();
        pix        = 0;
        prev_valid = 1'b0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_out_valid", out_valid, 0);
          end else begin
            e = sb.pop_front();
            $display("cyc=%0d pix=%0d out_data=%0d exp=%0d out_last=%0b", cyc, pix,
                     out_data, e.data, out_last);
            chk("pix_data", out_data, e.data);
            chk("pix_last", out_last, e.last);
          end
          if (pix != 0) chk("out_contiguous", prev_valid, 1);
          if (pix == 0) begin
            start_cycs.push_back(cyc);
            start_vals.push_back(int'(out_data));
          end
          pix = (pix == 63) ? 0 : pix + 1;
        end
        prev_valid = out_valid;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    fork
      monitor();
    join_none
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", busy, 0);

    // 1. DC block: every pixel 8, fixed latency.
    for (int i = 0; i < 64; i++) cur[i] = 0;
    cur[0] = 64;
    start_cycs.delete();
    push_const(8);
    drive_block(0, 64);
    chk("dc_busy_in_flight", busy, 1);
    wait_drain("dc", 200);
    chk("dc_blocks_seen", start_cycs.size(), 1);
    chk("dc_latency", start_cycs[0] - in63_cyc, 18);
    tick(3);
    chk("dc_busy_after", busy, 0);

    // 2. Impulse at u_col=1.
    for (int i = 0; i < 64; i++) cur[i] = 0;
    cur[1] = 256;
    push_model();
    drive_block(0, 64);
    wait_drain("impulse", 200);

    // 3. Four back-to-back random blocks.
    start_cycs.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 64; i++) cur[i] = int'($urandom_range(0, 4095)) - 2048;
      if (b == 0) for (int i = 0; i < 64; i++) blk0[i] = cur[i];
      push_model();
      drive_block(0, 64);
    end
    wait_drain("b2b", 400);
    chk("b2b_blocks_seen", start_cycs.size(), 4);
    for (int b = 1; b < 4; b++) chk("b2b_block_spacing", start_cycs[b] - start_cycs[b - 1], 64);

    // 4. Same data as block 0 with ~50% input gaps.
    for (int i = 0; i < 64; i++) cur[i] = blk0[i];
    push_model();
    drive_block(50, 64);
    wait_drain("gaps", 300);

    // 5. Saturation both ways.
    start_vals.delete();
    for (int i = 0; i < 64; i++) cur[i] = 2047;
    push_model();
    drive_block(0, 64);
    for (int i = 0; i < 64; i++) cur[i] = -2048;
    push_model();
    drive_block(0, 64);
    wait_drain("sat", 300);
    chk("sat_blocks_seen", start_vals.size(), 2);
    chk("sat_pos_clamp", start_vals[0], 511);
    chk("sat_neg_clamp", start_vals[1], -512);

    // 6a. Flush after input 30 (flush with in_valid drops the sample), then DC.
    for (int i = 0; i < 64; i++) cur[i] = int'($urandom_range(0, 4095)) - 2048;
    drive_block(0, 31);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'h123;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    tick(5);
    for (int i = 0; i < 64; i++) cur[i] = 0;
    cur[0] = 64;
    start_cycs.delete();
    push_const(8);
    drive_block(0, 64);
    wait_drain("flush_dc", 200);
    chk("flush_dc_latency", start_cycs[0] - in63_cyc, 18);

    // 6b. Reset in the middle of the column output, then a fresh DC block.
    push_const(8);
    drive_block(0, 64);
    k = 0;
    while (sb.size() > 54 && k < 200) begin
      tick(1);
      k++;
    end
    chk("midrst_started_output", sb.size() <= 54, 1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    tick(120);
    chk("midrst_idle_busy", busy, 0);
    start_cycs.delete();
    push_const(8);
    drive_block(0, 64);
    wait_drain("midrst_dc", 200);
    chk("midrst_blocks_seen", start_cycs.size(), 1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
